dso_sync_fifo: RTL and testbench

Parametrised single-clock FIFO for DSO sample buffering. It is the successor to the fixed 1024x8 sync FIFO. It adds generic width and depth, and a selectable first-word-fall-through (FWFT) read mode. Almost-full and almost-empty thresholds are runtime programmable, and a live fill level is exported. Sticky overflow/underflow flags and a synchronous flush are also provided. It sits between the ADC capture/trigger logic and the display/readout path.

---
 rtl/dso_fifo_pkg.sv | 28 ++
 rtl/dso_fifo_ram.sv | 36 +++
 rtl/dso_sync_fifo.sv | 233 +++++++++++++++++++++++
 tb/tb_dso_sync_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_fifo_pkg.sv
// Shared constants and helpers for the DSO sample-buffer FIFO family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dso_fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0)
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Level counter width: one extra bit so that "full" (== DEPTH) is representable
    function automatic int lvl_w(input int depth_w);
        return depth_w + 1;
    endfunction

endpackage

// File: rtl/dso_fifo_ram.sv
// Simple dual-port sample RAM, DEPTH x DATA_W, one write port and one registered read port.
// Latency: read data valid one cycle after rd_en; write visible to reads from the next cycle.
// Backpressure: none; the caller guarantees address legality and never stalls the RAM.
module dso_fifo_ram
    import dso_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Synchronous read port; output register holds while rd_en is low
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dso_sync_fifo.sv
// Single-clock parametrised sample FIFO with standard or first-word-fall-through read mode.
// Latency: std mode data 1 cycle after accepted rd_en; FWFT mode head word visible 2 cycles after write to empty.
// Backpressure: writes refused while wr_full, reads refused while rd_empty; refused requests only set sticky flags.
module dso_sync_fifo
    import dso_fifo_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH_W = 10,
    parameter int FWFT    = FIFO_STD,
    parameter int AF_RST  = 2**DEPTH_W - 4,
    parameter int AE_RST  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_full,
    output logic               almost_full,
    input  logic               rd_en,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_empty,
    output logic               almost_empty,
    output logic [DEPTH_W:0]   level,
    input  logic [DEPTH_W:0]   af_thresh,
    input  logic               af_thresh_ld,
    input  logic [DEPTH_W:0]   ae_thresh,
    input  logic               ae_thresh_ld,
    output logic               overflow,
    output logic               underflow,
    input  logic               clr_err
);

    localparam int               DEPTH    = 1 << DEPTH_W;
    localparam int               LVL_W    = lvl_w(DEPTH_W);
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_RST_L = LVL_W'(AF_RST);
    localparam logic [LVL_W-1:0] AE_RST_L = LVL_W'(AE_RST);

    // Thresholds beyond the physical depth behave as "exactly full"
    function automatic logic [LVL_W-1:0] sat_thr(input logic [LVL_W-1:0] t);
        return (t > DEPTH_L) ? DEPTH_L : t;
    endfunction

    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic [LVL_W-1:0]   level_q;
    logic [LVL_W-1:0]   level_nxt;
    logic [LVL_W-1:0]   af_thr;
    logic [LVL_W-1:0]   ae_thr;
    logic               full_q;
    logic               af_q;
    logic               ae_q;
    logic               ovf_q;
    logic               udf_q;
    logic               empty_w;
    logic               wr_acc;
    logic               rd_acc;
    logic               ovf_set;
    logic               udf_set;
    logic               ram_re;
    logic [DATA_W-1:0]  ram_q;

    // Handshakes; flush swallows any same-cycle request, including its error side effects
    assign wr_acc  = wr_en && !full_q  && !flush;
    assign rd_acc  = rd_en && !empty_w && !flush;
    assign ovf_set = wr_en && full_q   && !flush;
    assign udf_set = rd_en && empty_w  && !flush;

    // Next fill level: a simultaneous accepted write and read cancel out
    always_comb begin
        level_nxt = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level_q + 1'b1;
            2'b01:   level_nxt = level_q - 1'b1;
            default: level_nxt = level_q;
        endcase
    end

    // Level, status flags and write pointer, all committed on the same edge as the access
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            wr_ptr  <= '0;
        end else begin
            level_q <= level_nxt;
            full_q  <= (level_nxt == DEPTH_L);
            af_q    <= (level_nxt >= af_thr);
            ae_q    <= (level_nxt <= ae_thr);
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Read pointer follows RAM read issues (demand reads in std mode, prefetches in FWFT)
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
        end else if (ram_re) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Runtime thresholds: only reset or an explicit load changes them
    always_ff @(posedge clk) begin
        if (rst) begin
            af_thr <= AF_RST_L;
            ae_thr <= AE_RST_L;
        end else begin
            if (af_thresh_ld) begin
                af_thr <= sat_thr(af_thresh);
            end
            if (ae_thresh_ld) begin
                ae_thr <= sat_thr(ae_thresh);
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (udf_set) begin
                udf_q <= 1'b1;
            end else if (clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    dso_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (DEPTH_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Prefetch pipeline: RAM -> RAM output stage (q_vld) -> holding register (hold_vld).
            // level counts words in all three places, so the RAM-resident count is derived.
            logic              q_vld;
            logic              hold_vld;
            logic [DATA_W-1:0] hold_dat;
            logic [LVL_W-1:0]  ram_cnt;
            logic              q_take;
            logic              fetch;

            assign ram_cnt = level_q - LVL_W'(q_vld) - LVL_W'(hold_vld);
            assign q_take  = q_vld && (!hold_vld || rd_acc);
            assign fetch   = (ram_cnt != '0) && (!q_vld || q_take);

            // Advance the prefetch stages; a pop refills the holding register without a bubble
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    q_vld    <= 1'b0;
                    hold_vld <= 1'b0;
                    hold_dat <= '0;
                end else begin
                    if (fetch) begin
                        q_vld <= 1'b1;
                    end else if (q_take) begin
                        q_vld <= 1'b0;
                    end
                    if (q_take) begin
                        hold_vld <= 1'b1;
                        hold_dat <= ram_q;
                    end else if (rd_acc) begin
                        hold_vld <= 1'b0;
                    end
                end
            end

            assign ram_re  = fetch;
            assign empty_w = !hold_vld;
            assign rd_data = hold_dat;
        end else begin : g_std
            // Standard mode: the RAM output register is the read data register.
            // dout_vld masks the unreset RAM register until the first real read.
            logic empty_q;
            logic dout_vld;

            // Empty flag tracks the committed level
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    empty_q <= 1'b1;
                end else begin
                    empty_q <= (level_nxt == '0);
                end
            end

            // Remember that rd_data now holds a genuine word
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_vld <= 1'b0;
                end else if (rd_acc) begin
                    dout_vld <= 1'b1;
                end
            end

            assign ram_re  = rd_acc;
            assign empty_w = empty_q;
            assign rd_data = dout_vld ? ram_q : '0;
        end
    endgenerate

    assign wr_full      = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign rd_empty     = empty_w;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_dso_sync_fifo.sv
// Scoreboard bench for dso_sync_fifo: one standard-mode and one FWFT instance, DEPTH 16.
// Latency: stimulus applied 1 time unit after the rising edge, flags checked 1 unit after the next edge.
// Backpressure: read data is compared by negedge monitors whenever the DUT handshakes a read.
module tb_dso_sync_fifo;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       af_ld = 1'b0;
    logic       ae_ld = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [4:0] af_thresh = 5'd0;
    logic [4:0] ae_thresh = 5'd0;
    logic [7:0] rd_data;
    logic [4:0] level;
    logic       wr_full, almost_full, rd_empty, almost_empty, overflow, underflow;

    logic       f_wr_en = 1'b0;
    logic       f_rd_en = 1'b0;
    logic [7:0] f_wr_data = 8'h00;
    logic [7:0] f_rd_data;
    logic [4:0] f_level;
    logic       f_wr_full, f_af, f_rd_empty, f_ae, f_ovf, f_udf;

    dso_sync_fifo #(.DATA_W(8), .DEPTH_W(4), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .almost_empty(almost_empty),
        .level(level), .af_thresh(af_thresh), .af_thresh_ld(af_ld),
        .ae_thresh(ae_thresh), .ae_thresh_ld(ae_ld),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    dso_sync_fifo #(.DATA_W(8), .DEPTH_W(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(1'b0),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_full(f_wr_full), .almost_full(f_af),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_empty(f_rd_empty), .almost_empty(f_ae),
        .level(f_level), .af_thresh(5'd0), .af_thresh_ld(1'b0),
        .ae_thresh(5'd0), .ae_thresh_ld(1'b0),
        .overflow(f_ovf), .underflow(f_udf), .clr_err(1'b0)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: queue contents, thresholds, sticky flags
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_f[$];
    int         af_m = 12;
    int         ae_m = 4;
    bit         ovf_m = 1'b0;
    bit         udf_m = 1'b0;
    bit         e_af = 1'b0;
    bit         e_ae = 1'b1;
    logic [7:0] last_pop = 8'h00;
    bit         pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_state();
        chk("level", 32'(level), 32'(mq.size()));
        chk("wr_full", 32'(wr_full), 32'(mq.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(e_af));
        chk("almost_empty", 32'(almost_empty), 32'(e_ae));
        chk("rd_empty", 32'(rd_empty), 32'(mq.size() == 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("underflow", 32'(underflow), 32'(udf_m));
    endtask

    // One clock of standard-instance stimulus, model update, then post-edge state check
    task automatic step(input bit we, input logic [7:0] wd, input bit re,
                        input bit fl = 1'b0, input bit rs = 1'b0, input bit clr = 1'b0,
                        input bit afl = 1'b0, input int afv = 0,
                        input bit ael = 1'b0, input int aev = 0);
        int sz;
        bit so;
        bit su;
        wr_en = we; wr_data = wd; rd_en = re; flush = fl; rst = rs; clr_err = clr;
        af_ld = afl; af_thresh = 5'(afv); ae_ld = ael; ae_thresh = 5'(aev);
        sz = mq.size();
        if (rs) begin
            mq.delete();
            ovf_m = 1'b0; udf_m = 1'b0;
            af_m = 12; ae_m = 4;
        end else begin
            so = !fl && we && (sz == DEPTH);
            su = !fl && re && (sz == 0);
            ovf_m = so || (ovf_m && !clr);
            udf_m = su || (udf_m && !clr);
            if (fl) begin
                mq.delete();
            end else begin
                if (re && sz > 0) begin
                    last_pop = mq.pop_front();
                    exp_q.push_back(last_pop);
                end
                if (we && sz < DEPTH) mq.push_back(wd);
            end
        end
        e_af = (mq.size() >= af_m);
        e_ae = (mq.size() <= ae_m);
        if (!rs) begin
            if (afl) af_m = (afv > DEPTH) ? DEPTH : afv;
            if (ael) ae_m = (aev > DEPTH) ? DEPTH : aev;
        end
        @(posedge clk); #1;
        check_state();
    endtask

    // Standard-mode monitor: a handshaked read shows its word one edge later
    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL std_rd_extra: got %0h, no word expected", rd_data);
            end else begin
                chk("std_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
        pend = rd_en && !rd_empty;
    end

    // FWFT monitor: the word on rd_data is consumed in the handshake cycle
    always @(negedge clk) begin
        if (f_rd_en && !f_rd_empty) begin
            if (exp_f.size() == 0) begin
                n_chk++;
                $display("FAIL fwft_rd_extra: got %0h, no word expected", f_rd_data);
            end else begin
                chk("fwft_rd_data", 32'(f_rd_data), 32'(exp_f.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("fwft_rst_empty", 32'(f_rd_empty), 32'h1);
        chk("fwft_rst_level", 32'(f_level), 32'h0);

        // Fill 0x00..0x0F, then a refused write of 0xAA
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_after_full_write", 32'(overflow), 32'h1);

        // Drain 16 words plus one read on empty
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("rd_data_hold", 32'(rd_data), 32'(last_pop));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Steady level 8 across the pointer wrap
        for (int i = 0; i < 15; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 7; i++)  step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1);

        // Random traffic
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0)),
                 1'b0, 1'b0, ($urandom_range(15, 0) == 0));

        // Thresholds, saturation and the full-with-read case
        while (mq.size() > 0) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6, 1'b1, 2);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
        chk("af_at_6", 32'(almost_full), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 31);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        step(1'b1, 8'hBB, 1'b1);
        chk("full_rw_level", 32'(level), 32'd15);

        // Flush at level 9, thresholds kept, then reset mid-burst
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        chk("flush_ovf_kept", 32'(overflow), 32'h1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_rd_data", 32'(rd_data), 32'h0);
        for (int i = 0; i < 13; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("std_sb_drained", 32'(exp_q.size()), 32'h0);

        // FWFT: single word latency into an empty FIFO
        f_wr_en = 1'b1; f_wr_data = 8'h5A; exp_f.push_back(8'h5A);
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        chk("fwft_k_empty", 32'(f_rd_empty), 32'h1);
        chk("fwft_k_level", 32'(f_level), 32'h1);
        @(posedge clk); #1;
        chk("fwft_k1_empty", 32'(f_rd_empty), 32'h1);
        @(posedge clk); #1;
        chk("fwft_k2_empty", 32'(f_rd_empty), 32'h0);
        chk("fwft_k2_data", 32'(f_rd_data), 32'h5A);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        chk("fwft_pop_empty", 32'(f_rd_empty), 32'h1);
        chk("fwft_pop_level", 32'(f_level), 32'h0);

        // FWFT: back-to-back pops without a bubble
        for (int i = 0; i < 4; i++) begin
            f_wr_en = 1'b1; f_wr_data = 8'($urandom); exp_f.push_back(f_wr_data);
            @(posedge clk); #1;
        end
        f_wr_en = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        f_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fwft_no_bubble", 32'(f_rd_empty), 32'h0);
            @(posedge clk); #1;
        end
        f_rd_en = 1'b0;
        chk("fwft_burst_empty", 32'(f_rd_empty), 32'h1);

        // FWFT: random traffic, never overfilling
        for (int i = 0; i < 150; i++) begin
            chk("fwft_level", 32'(f_level), 32'(exp_f.size()));
            f_wr_en = (exp_f.size() < DEPTH) && ($urandom_range(1, 0) == 1);
            f_wr_data = 8'($urandom);
            if (f_wr_en) exp_f.push_back(f_wr_data);
            f_rd_en = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
        end
        f_wr_en = 1'b0;
        f_rd_en = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        f_rd_en = 1'b0;
        chk("fwft_drain_left", 32'(exp_f.size()), 32'h0);
        chk("fwft_drain_level", 32'(f_level), 32'h0);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
